alu_slice_sequencer: RTL and testbench

//  Multi-cycle controller that performs W-bit (W = N*SLICES) add/subtract operations on an external

---
 rtl/alu_slice_sequencer.sv | 146 ++++++++++++++
 tb/tb_alu_slice_sequencer.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/alu_slice_sequencer.sv
// alu_slice_sequencer: runs W-bit add/subtract operations (W = N*SLICES) on an
// external combinational N-bit adder, one slice per clock, LSB slice first.
// It keeps a persistent carry flag so ADC/SBB can chain into wider arithmetic.
// Optional feature macro: ALU_SEQ_FLAGS_EN adds the out_zero and out_ovf outputs.
module alu_slice_sequencer #(
    parameter int N      = 4,
    parameter int SLICES = 4,
    localparam int W     = N * SLICES
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [1:0]   in_op,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    output logic [N-1:0] slice_a,
    output logic [N-1:0] slice_b,
    output logic         slice_cin,
    output logic [1:0]   slice_ctrl,
    input  logic [N-1:0] slice_sum,
    input  logic         slice_cout,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_result,
    output logic         out_carry,
`ifdef ALU_SEQ_FLAGS_EN
    output logic         out_zero,
    output logic         out_ovf,
`endif
    output logic         busy
);

    localparam int IDX_W = (SLICES > 1) ? $clog2(SLICES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SLICES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state;
    logic [IDX_W-1:0] idx;
    logic [W-1:0]   a_r;
    logic [W-1:0]   b_r;
    logic [1:0]     op_r;
    logic           chain_c;
    logic           carry_flag;
    logic [W-1:0]   res_nxt;
    logic           accept;

    assign accept = in_valid && in_ready;

    // Drive the adder from the latched operands during RUN; park it at zero otherwise.
    always_comb begin
        slice_a    = '0;
        slice_b    = '0;
        slice_cin  = 1'b0;
        slice_ctrl = 2'b00;
        if (state == RUN) begin
            slice_a    = a_r[idx*N +: N];
            slice_b    = b_r[idx*N +: N];
            slice_ctrl = {1'b0, op_r[0]};
            if (idx == '0) begin
                case (op_r)
                    2'b00:   slice_cin = 1'b0;
                    2'b01:   slice_cin = 1'b1;
                    default: slice_cin = carry_flag;
                endcase
            end else begin
                slice_cin = chain_c;
            end
        end
    end

    // Result as it will look after the current slice sum is written in.
    always_comb begin
        res_nxt = out_result;
        res_nxt[idx*N +: N] = slice_sum;
    end

    // Operand capture and inter-slice carry; pure data, no reset needed.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_r  <= in_a;
            b_r  <= in_b;
            op_r <= in_op;
        end
        if (state == RUN) begin
            chain_c <= slice_cout;
        end
    end

    // Control FSM with registered handshake, status and result outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            idx        <= '0;
            carry_flag <= 1'b0;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_carry  <= 1'b0;
            busy       <= 1'b0;
            in_ready   <= 1'b1;
`ifdef ALU_SEQ_FLAGS_EN
            out_zero   <= 1'b0;
            out_ovf    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state    <= RUN;
                        idx      <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                RUN: begin
                    out_result <= res_nxt;
                    if (idx == LAST_IDX) begin
                        state      <= DONE;
                        out_valid  <= 1'b1;
                        out_carry  <= slice_cout;
                        carry_flag <= slice_cout;
`ifdef ALU_SEQ_FLAGS_EN
                        out_zero   <= (res_nxt == '0);
                        // Overflow when both addends share a sign the result does not.
                        out_ovf    <= (a_r[W-1] == (b_r[W-1] ^ op_r[0])) &&
                                      (slice_sum[N-1] != a_r[W-1]);
`endif
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_slice_sequencer.sv
// Directed bench for alu_slice_sequencer with N=4, SLICES=4 and a behavioural
// 4-bit adder slice: sum = A + (ctrl[0] ? ~B : B) + cin.
module tb_alu_slice_sequencer;

    localparam int N      = 4;
    localparam int SLICES = 4;
    localparam int W      = N * SLICES;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   in_op;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic [N-1:0] slice_a;
    logic [N-1:0] slice_b;
    logic         slice_cin;
    logic [1:0]   slice_ctrl;
    logic [N-1:0] slice_sum;
    logic         slice_cout;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_result;
    logic         out_carry;
    logic         busy;
`ifdef ALU_SEQ_FLAGS_EN
    logic         out_zero;
    logic         out_ovf;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Behavioural adder slice.
    logic [N-1:0] b_eff;
    assign b_eff = slice_ctrl[0] ? ~slice_b : slice_b;
    assign {slice_cout, slice_sum} = {1'b0, slice_a} + {1'b0, b_eff} + {{N{1'b0}}, slice_cin};

    alu_slice_sequencer #(.N(N), .SLICES(SLICES)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .slice_a    (slice_a),
        .slice_b    (slice_b),
        .slice_cin  (slice_cin),
        .slice_ctrl (slice_ctrl),
        .slice_sum  (slice_sum),
        .slice_cout (slice_cout),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_carry  (out_carry),
`ifdef ALU_SEQ_FLAGS_EN
        .out_zero   (out_zero),
        .out_ovf    (out_ovf),
`endif
        .busy       (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one operation and wait for the result; leaves the bench in DONE.
    task automatic start_op(input string tag, input logic [1:0] op, input logic [W-1:0] a,
                            input logic [W-1:0] b, input logic [W-1:0] exp_res,
                            input logic exp_c);
        int lat;
        @(negedge clk);
        in_op = op; in_a = a; in_b = b; in_valid = 1'b1;
        check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_a = ~a; in_b = ~b; in_op = ~op;
        check({tag, ".ctrl"}, 32'(slice_ctrl), {30'd0, 1'b0, op[0]});
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, ".latency"}, 32'(lat), 32'd4);
        check({tag, ".result"}, 32'(out_result), 32'(exp_res));
        check({tag, ".carry"}, 32'(out_carry), 32'(exp_c));
    endtask

    // Complete the output handshake and confirm the return to IDLE.
    task automatic finish_op(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        check({tag, ".idle_valid"}, 32'(out_valid), 32'd0);
        check({tag, ".idle_ready"}, 32'(in_ready), 32'd1);
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] exp_res,
                          input logic exp_c);
        start_op(tag, op, a, b, exp_res, exp_c);
        finish_op(tag);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_op = 2'b00; in_a = '0; in_b = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst.in_ready", 32'(in_ready), 32'd1);
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.out_valid", 32'(out_valid), 32'd0);
        check("rst.out_result", 32'(out_result), 32'd0);
        check("rst.out_carry", 32'(out_carry), 32'd0);
        check("rst.slice_a", 32'(slice_a), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Carry propagation across slices.
        run_op("add_ff", 2'b00, 16'h00FF, 16'h0001, 16'h0100, 1'b0);
        // Borrow out, then chained SBB consumes the cleared carry flag.
        run_op("sub_borrow", 2'b01, 16'h0000, 16'h0001, 16'hFFFF, 1'b0);
        run_op("sbb_chain", 2'b11, 16'h0000, 16'h0000, 16'hFFFF, 1'b0);
        // Carry out, then chained ADC consumes the set carry flag.
        run_op("add_wrap", 2'b00, 16'hFFFF, 16'h0001, 16'h0000, 1'b1);
        run_op("adc_chain", 2'b10, 16'h0000, 16'h0000, 16'h0001, 1'b0);

        // Consumer stall in DONE with a competing request present.
        out_ready = 1'b0;
        start_op("stall", 2'b00, 16'h1111, 16'h2222, 16'h3333, 1'b0);
        @(negedge clk);
        in_valid = 1'b1; in_op = 2'b00; in_a = 16'h0101; in_b = 16'h0202;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("stall.held", 32'(out_result), 32'h3333);
            check("stall.in_ready", 32'(in_ready), 32'd0);
            check("stall.busy", 32'(busy), 32'd1);
        end
        in_valid = 1'b0;
        finish_op("stall");
        run_op("after_stall", 2'b00, 16'h0101, 16'h0202, 16'h0303, 1'b0);

        // Reset during RUN slice 2 must clear the carry flag.
        run_op("set_flag", 2'b00, 16'hFFFF, 16'h0001, 16'h0000, 1'b1);
        @(negedge clk);
        in_valid = 1'b1; in_op = 2'b00; in_a = 16'h4444; in_b = 16'h4444;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("mid.slice_a", 32'(slice_a), 32'h4);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("mid_rst.in_ready", 32'(in_ready), 32'd1);
        check("mid_rst.busy", 32'(busy), 32'd0);
        check("mid_rst.out_valid", 32'(out_valid), 32'd0);
        check("mid_rst.out_carry", 32'(out_carry), 32'd0);
        run_op("adc_after_rst", 2'b10, 16'h0001, 16'h0001, 16'h0002, 1'b0);

`ifdef ALU_SEQ_FLAGS_EN
        start_op("ovf", 2'b00, 16'h7FFF, 16'h0001, 16'h8000, 1'b0);
        check("ovf.out_ovf", 32'(out_ovf), 32'd1);
        check("ovf.out_zero", 32'(out_zero), 32'd0);
        finish_op("ovf");
        start_op("zero", 2'b01, 16'h1234, 16'h1234, 16'h0000, 1'b1);
        check("zero.out_zero", 32'(out_zero), 32'd1);
        check("zero.out_ovf", 32'(out_ovf), 32'd0);
        finish_op("zero");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
